// File: rtl/dn_loader_ctrl.sv
// dn_loader_ctrl: sequences a byte-wide ROM download into three address regions.
// Each download byte is buffered for one write handshake. The game core is held
// in reset until the buffer has drained and a fixed hold period has elapsed.
// Optional feature: define LOADER_CHECKSUM_EN to add an 8-bit running checksum
// output over every byte strobed during a load.
module dn_loader_ctrl #(
  parameter logic [15:0] REGION1_BASE = 16'h6000,
  parameter logic [15:0] REGION2_BASE = 16'h8000,
  parameter logic [15:0] ROM_TOP      = 16'h9000,
  parameter int          HOLD_CYCLES  = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        wr_rdy,
  output logic [2:0]  rom_sel,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_we,
  output logic        core_reset,
  output logic        load_done,
  output logic        overflow,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]  checksum,
`endif
  output logic [16:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [16:0] COUNT_MAX = 17'h1FFFF;

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic [2:0]  rom_sel_q, rom_sel_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        rom_we_q, rom_we_d;
  logic        core_reset_q, core_reset_d;
  logic        load_done_q, load_done_d;
  logic        overflow_q, overflow_d;
  logic [16:0] byte_count_q, byte_count_d;
  logic [7:0]  hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum_q, checksum_d;
`endif

  // Region decode of the incoming byte address.
  logic        in_range;
  logic [2:0]  dec_sel;
  logic [15:0] dec_off;

  // Map a download address onto a one-hot region and an offset inside it.
  always_comb begin
    in_range = 1'b1;
    dec_sel  = 3'b000;
    dec_off  = 16'h0000;
    if (dn_addr < REGION1_BASE) begin
      dec_sel = 3'b001;
      dec_off = dn_addr;
    end else if (dn_addr < REGION2_BASE) begin
      dec_sel = 3'b010;
      dec_off = dn_addr - REGION1_BASE;
    end else if (dn_addr < ROM_TOP) begin
      dec_sel = 3'b100;
      dec_off = dn_addr - REGION2_BASE;
    end else begin
      in_range = 1'b0;
    end
  end

  logic rise;
  logic complete;
  logic buf_free;

  assign rise     = dn_download & ~dl_q;
  assign complete = rom_we_q & wr_rdy;
  // A completing write frees the buffer in the same cycle for a new byte.
  assign buf_free = ~rom_we_q | wr_rdy;

  // Next-state logic for the control FSM, write buffer and load statistics.
  always_comb begin
    state_d      = state_q;
    dl_d         = dn_download;
    rom_sel_d    = rom_sel_q;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    rom_we_d     = rom_we_q;
    overflow_d   = overflow_q;
    byte_count_d = byte_count_q;
    hold_d       = hold_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    // A handshake retires the buffered write in every state, so a write left
    // pending across DRAIN/HOLD/LOAD transitions still finishes normally.
    if (complete) rom_we_d = 1'b0;

    case (state_q)
      IDLE, RUN: begin
        if (rise) state_d = LOAD;
      end
      LOAD: begin
        if (dn_wr) begin
          if (byte_count_q != COUNT_MAX) byte_count_d = byte_count_q + 17'd1;
`ifdef LOADER_CHECKSUM_EN
          checksum_d = checksum_q + dn_data;
`endif
          if (buf_free) begin
            // Out-of-range bytes are counted but never written.
            if (in_range) begin
              rom_we_d   = 1'b1;
              rom_sel_d  = dec_sel;
              rom_addr_d = dec_off;
              rom_data_d = dn_data;
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (!dn_download) state_d = DRAIN;
      end
      DRAIN: begin
        if (rise) begin
          state_d = LOAD;
        end else if (!rom_we_q) begin
          state_d = HOLD;
          hold_d  = 8'd0;
        end
      end
      HOLD: begin
        if (rise) begin
          state_d = LOAD;
          hold_d  = 8'd0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = 8'd0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh load starts with clean statistics; the buffered write is kept.
    if (state_d == LOAD && state_q != LOAD) begin
      byte_count_d = 17'd0;
      overflow_d   = 1'b0;
      hold_d       = 8'd0;
`ifdef LOADER_CHECKSUM_EN
      checksum_d   = 8'd0;
`endif
    end

    core_reset_d = (state_d != RUN);
    load_done_d  = (state_d == RUN);
  end

  // State and registered outputs, all cleared asynchronously by reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      rom_sel_q    <= 3'b000;
      rom_addr_q   <= 16'h0000;
      rom_data_q   <= 8'h00;
      rom_we_q     <= 1'b0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= 17'd0;
      hold_q       <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      rom_sel_q    <= rom_sel_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      rom_we_q     <= rom_we_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      hold_q       <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign rom_sel    = rom_sel_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign rom_we     = rom_we_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_dn_loader_ctrl.sv
// Directed testbench for dn_loader_ctrl with hand-computed expected values.
module tb_dn_loader_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        wr_rdy;
  logic [2:0]  rom_sel;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_we;
  logic        core_reset;
  logic        load_done;
  logic        overflow;
  logic [16:0] byte_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  dn_loader_ctrl dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .wr_rdy      (wr_rdy),
    .rom_sel     (rom_sel),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rom_we      (rom_we),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .overflow    (overflow),
`ifdef LOADER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .byte_count  (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_done = 0;

  // Count completed write handshakes at the active edge.
  always @(posedge clk_sys) begin
    if (reset_n && rom_we && wr_rdy) wr_done = wr_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d);
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    tick();
    dn_wr = 1'b0;
  endtask

  logic ok;
  int   base;

  initial begin
    reset_n = 1'b0; dn_download = 1'b0; dn_wr = 1'b0;
    dn_addr = 16'h0; dn_data = 8'h0; wr_rdy = 1'b1;

    // Reset state
    #23;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_rom_we",     32'(rom_we),     32'd0);
    chk("rst_load_done",  32'(load_done),  32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_rom_sel",    32'(rom_sel),    32'd0);
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_core_reset", 32'(core_reset), 32'd1);

    // Three-region download with wr_rdy high, back-to-back strobes
    dn_download = 1'b1;
    tick();
    chk("load_entry_core_reset", 32'(core_reset), 32'd1);
    dn_wr = 1'b1; dn_addr = 16'h0000; dn_data = 8'h11; tick();
    chk("b0_sel",  32'(rom_sel),  32'h1);
    chk("b0_addr", 32'(rom_addr), 32'h0000);
    chk("b0_data", 32'(rom_data), 32'h11);
    chk("b0_we",   32'(rom_we),   32'd1);
    dn_addr = 16'h6001; dn_data = 8'h22; tick();
    chk("b1_sel",  32'(rom_sel),  32'h2);
    chk("b1_addr", 32'(rom_addr), 32'h0001);
    chk("b1_data", 32'(rom_data), 32'h22);
    dn_addr = 16'h8002; dn_data = 8'h33; tick();
    chk("b2_sel",  32'(rom_sel),  32'h4);
    chk("b2_addr", 32'(rom_addr), 32'h0002);
    chk("b2_count", 32'(byte_count), 32'd3);
    dn_wr = 1'b0; tick();
    chk("b2_we_clear", 32'(rom_we), 32'd0);
    chk("b_writes",    32'(wr_done), 32'd3);

    // Stall with a pending byte, then an overflow strobe
    wr_rdy = 1'b0;
    send(16'h0010, 8'h44);
    chk("stall_we",    32'(rom_we), 32'd1);
    chk("stall_count", 32'(byte_count), 32'd4);
    base = wr_done;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        dn_wr = 1'b1; dn_addr = 16'h0020; dn_data = 8'h55;
      end
      tick();
      dn_wr = 1'b0;
      if (!(rom_we == 1'b1 && rom_addr == 16'h0010 && rom_data == 8'h44 && rom_sel == 3'b001)) ok = 1'b0;
    end
    chk("stall_stable",   32'(ok), 32'd1);
    chk("stall_overflow", 32'(overflow), 32'd1);
    chk("stall_count2",   32'(byte_count), 32'd5);
    chk("stall_no_write", 32'(wr_done - base), 32'd0);
    wr_rdy = 1'b1;
    tick();
    chk("stall_done_we",  32'(rom_we), 32'd0);
    chk("stall_one_write", 32'(wr_done - base), 32'd1);
    chk("stall_kept_data", 32'(rom_data), 32'h44);

    // Out-of-range byte and the last in-range address
    base = wr_done;
    send(16'h9000, 8'h66);
    chk("oor_we",    32'(rom_we), 32'd0);
    chk("oor_count", 32'(byte_count), 32'd6);
    tick();
    chk("oor_no_write", 32'(wr_done - base), 32'd0);
    send(16'h8FFF, 8'h99);
    chk("top_sel",   32'(rom_sel),  32'h4);
    chk("top_addr",  32'(rom_addr), 32'h0FFF);
    chk("top_count", 32'(byte_count), 32'd7);
    tick();
    chk("top_write", 32'(wr_done - base), 32'd1);

    // Download ends: drain, 16 hold cycles, then run
    dn_download = 1'b0;
    tick();
    chk("drain_core_reset", 32'(core_reset), 32'd1);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!(core_reset == 1'b1 && load_done == 1'b0)) ok = 1'b0;
    end
    chk("hold_core_reset", 32'(ok), 32'd1);
    tick();
    chk("run_core_reset", 32'(core_reset), 32'd0);
    chk("run_load_done",  32'(load_done),  32'd1);
    chk("run_count",      32'(byte_count), 32'd7);

    // New load from RUN; pending write survives a DRAIN->LOAD restart
    wr_rdy = 1'b0;
    dn_download = 1'b1;
    tick();
    chk("reload_load_done",  32'(load_done),  32'd0);
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_count",      32'(byte_count), 32'd0);
    chk("reload_overflow",   32'(overflow),   32'd0);
    send(16'h6000, 8'h77);
    chk("r1_sel",  32'(rom_sel),  32'h2);
    chk("r1_addr", 32'(rom_addr), 32'h0000);
    dn_download = 1'b0;
    tick(); tick();
    chk("drain_pending_we", 32'(rom_we), 32'd1);
    dn_download = 1'b1;
    tick();
    chk("drain_rise_we",    32'(rom_we), 32'd1);
    chk("drain_rise_data",  32'(rom_data), 32'h77);
    chk("drain_rise_count", 32'(byte_count), 32'd0);
    wr_rdy = 1'b1;
    tick();
    chk("drain_rise_done", 32'(rom_we), 32'd0);
    send(16'h0005, 8'hF0);
    send(16'h9000, 8'h20);
    tick();
    chk("cs_count", 32'(byte_count), 32'd2);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'h10);
`endif

    // Rising download during HOLD restarts the load and the hold count
    dn_download = 1'b0;
    tick(); tick();
    repeat (5) tick();
    dn_download = 1'b1;
    tick();
    chk("hold_rise_core_reset", 32'(core_reset), 32'd1);
    chk("hold_rise_count",      32'(byte_count), 32'd0);
    chk("hold_rise_load_done",  32'(load_done),  32'd0);
    dn_download = 1'b0;
    tick(); tick();
    repeat (15) tick();
    chk("rehold_core_reset", 32'(core_reset), 32'd1);
    tick();
    chk("rehold_run", 32'(core_reset), 32'd0);

    // Reset during LOAD cancels the pending write
    wr_rdy = 1'b0;
    dn_download = 1'b1;
    tick();
    send(16'h0100, 8'hAA);
    chk("prerst_we", 32'(rom_we), 32'd1);
    base = wr_done;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_we",         32'(rom_we), 32'd0);
    chk("async_rst_core_reset", 32'(core_reset), 32'd1);
    chk("async_rst_sel",        32'(rom_sel), 32'd0);
    dn_download = 1'b0;
    #3 reset_n = 1'b1;
    tick(); tick();
    wr_rdy = 1'b1;
    tick();
    chk("postrst_we",       32'(rom_we), 32'd0);
    chk("postrst_no_write", 32'(wr_done - base), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
